// File: rtl/data_gen_pkg.sv
// Shared constants for the stream pattern generator/checker pair:
// LFSR seed and taps, counter widths, and the per-channel start word.
package data_gen_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int PKT_CNT_W = 32;
    localparam int ERR_CNT_W = 16;

    function automatic logic [15:0] init_word(input int unsigned ch);
        logic [15:0] c;
        c = 16'(ch);
        return {c[7:0], 8'h00} | c;
    endfunction

endpackage

// File: rtl/data_check_if.sv
// AXI-Stream bus carrying the test pattern; master drives data, slave drives ready.
interface data_check_if #(
    parameter int DW = 512
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic            tvalid;
    logic            tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/data_check_lfsr16.sv
// 16-bit Fibonacci LFSR with loadable seed; shared by generator and checker
// for randomised handshake timing.
module lfsr16
    import data_gen_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= LFSR_SEED;
        else if (load)
            state <= seed;
        else if (advance)
            state <= {state[14:0], ^(state & LFSR_TAPS)};
    end

endmodule

// File: rtl/data_check.sv
// Receive-side checker for the replicated incrementing 16-bit stream pattern:
// per-beat lane/keep check, packet framing check, and status counters.
module data_check
    import data_gen_pkg::*;
#(
    parameter int DW        = 512,
    parameter int CHANNEL   = 0,
    parameter int PKT_BEATS = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_check_if.slave          axis_in,
    input  logic                 throttle,
    input  logic                 clr_counts,
    output logic [PKT_CNT_W-1:0] pkt_count,
    output logic [ERR_CNT_W-1:0] data_err_count,
    output logic [ERR_CNT_W-1:0] frame_err_count,
    output logic [15:0]          first_bad_word,
    output logic                 error
);

    localparam int LANES = DW / 16;
    localparam int BW    = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [15:0] EXP_INIT = init_word(CHANNEL);

    logic [15:0]      lfsr_state;
    logic             ready_q;
    logic [15:0]      exp_word;
    logic [BW-1:0]    beat;
    logic [LANES-1:0] lane_bad;
    logic             acc;
    logic             beat_last;
    logic             data_bad;
    logic             frame_bad;
    logic             pkt_inc;
    logic [15:0]      rx;
    logic             unused_lfsr;

    lfsr16 u_lfsr (
        .clk     (clk),
        .resetn  (resetn),
        .load    (1'b0),
        .seed    (LFSR_SEED),
        .advance (1'b1),
        .state   (lfsr_state)
    );

    assign unused_lfsr = &{1'b0, lfsr_state[15:2]};

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_bad[g] = (axis_in.tdata[16*g +: 16] != exp_word);
    end

    assign axis_in.tready = ready_q;
    assign acc       = axis_in.tvalid & ready_q;
    assign rx        = axis_in.tdata[15:0];
    assign beat_last = (beat == BW'(PKT_BEATS - 1));
    assign data_bad  = acc & ((|lane_bad) | ~(&axis_in.tkeep));
    // TLAST early (short) or missing on the final beat (long)
    assign frame_bad = acc & (axis_in.tlast ^ beat_last);
    assign pkt_inc   = acc & axis_in.tlast;

    // Ready is registered so there is no combinational path from tvalid.
    always_ff @(posedge clk) begin
        if (!resetn)
            ready_q <= 1'b0;
        else
            ready_q <= throttle ? (lfsr_state[0] | lfsr_state[1]) : 1'b1;
    end

    // Expected word tracks the received lane 0 so one bad beat cannot cascade.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            exp_word <= EXP_INIT;
            beat     <= '0;
        end else if (acc) begin
            exp_word <= rx + 16'd1;
            beat     <= (axis_in.tlast | beat_last) ? '0 : beat + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clr_counts) begin
            pkt_count       <= '0;
            data_err_count  <= '0;
            frame_err_count <= '0;
            first_bad_word  <= '0;
            error           <= 1'b0;
        end else begin
            if (pkt_inc)
                pkt_count <= pkt_count + PKT_CNT_W'(1);
            if (data_bad && !(&data_err_count))
                data_err_count <= data_err_count + ERR_CNT_W'(1);
            if (frame_bad && !(&frame_err_count))
                frame_err_count <= frame_err_count + ERR_CNT_W'(1);
            if (data_bad && !error)
                first_bad_word <= rx;
            if (data_bad || frame_bad)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_check.sv
// Directed bench for data_check: a spec-level model compared every cycle,
// plus literal end-of-scenario expectations.
module tb_data_check;

    localparam int DW    = 512;
    localparam int LANES = DW / 16;
    localparam int KW    = DW / 8;
    localparam int PKT   = 8;
    localparam logic [15:0] START = 16'h0000;   // CHANNEL 0

    logic        clk = 1'b0;
    logic        resetn;
    logic        throttle;
    logic        clr_counts;
    logic [31:0] pkt_count;
    logic [15:0] data_err_count;
    logic [15:0] frame_err_count;
    logic [15:0] first_bad_word;
    logic        error;

    data_check_if #(.DW(DW)) axis ();

    data_check #(.DW(DW), .CHANNEL(0), .PKT_BEATS(PKT)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .axis_in         (axis),
        .throttle        (throttle),
        .clr_counts      (clr_counts),
        .pkt_count       (pkt_count),
        .data_err_count  (data_err_count),
        .frame_err_count (frame_err_count),
        .first_bad_word  (first_bad_word),
        .error           (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_live = 1'b0;
    logic        m_ready;
    logic [15:0] m_lfsr;
    logic [15:0] m_exp;
    int          m_pos;
    logic [31:0] m_pkt;
    int          m_derr, m_ferr;
    logic [15:0] m_fbw;
    logic        m_err;
    logic        thr_phase = 1'b0;
    int          ph_cyc = 0, ph_low = 0;

    initial begin
        logic          s_rst, s_thr, s_clr, s_v, s_l, acc, dbad, fbad;
        logic [DW-1:0] s_d;
        logic [KW-1:0] s_k;
        logic [15:0]   rx;
        forever begin
            @(posedge clk);
            s_rst = resetn; s_thr = throttle; s_clr = clr_counts;
            s_v = axis.tvalid; s_l = axis.tlast; s_d = axis.tdata; s_k = axis.tkeep;
            if (!s_rst) begin
                m_ready = 1'b0; m_lfsr = 16'hACE1; m_exp = START; m_pos = 0;
                m_pkt = 0; m_derr = 0; m_ferr = 0; m_fbw = 0; m_err = 1'b0;
                m_live = 1'b1;
            end else begin
                acc = s_v && m_ready;
                if (acc) begin
                    rx = s_d[15:0];
                    dbad = (s_k != {KW{1'b1}});
                    for (int i = 0; i < LANES; i++)
                        if (s_d[16*i +: 16] != m_exp) dbad = 1'b1;
                    fbad = s_l ? (m_pos != PKT-1) : (m_pos == PKT-1);
                    if (s_l) m_pkt = m_pkt + 1;
                    if (dbad && m_derr < 65535) m_derr++;
                    if (fbad && m_ferr < 65535) m_ferr++;
                    if (dbad && !m_err) m_fbw = rx;
                    if (dbad || fbad) m_err = 1'b1;
                    m_exp = rx + 16'd1;
                    m_pos = (s_l || m_pos == PKT-1) ? 0 : m_pos + 1;
                end
                if (s_clr) begin
                    m_pkt = 0; m_derr = 0; m_ferr = 0; m_fbw = 0; m_err = 1'b0;
                end
                m_ready = s_thr ? (m_lfsr[1:0] != 2'b00) : 1'b1;
                m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            end
            #1;
            if (m_live) begin
                chk("tready", 32'(axis.tready), 32'(m_ready));
                chk("pkt_count", pkt_count, m_pkt);
                chk("data_err_count", 32'(data_err_count), 32'(m_derr));
                chk("frame_err_count", 32'(frame_err_count), 32'(m_ferr));
                chk("first_bad_word", 32'(first_bad_word), 32'(m_fbw));
                chk("error", 32'(error), 32'(m_err));
            end
            if (thr_phase) begin
                ph_cyc++;
                if (!axis.tready) ph_low++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [15:0] w, input int bad_lane, input logic [15:0] bad_val,
                         input logic last, input logic [KW-1:0] keep, input logic clr);
        logic [DW-1:0] d;
        int waitc;
        waitc = 0;
        for (int i = 0; i < LANES; i++) d[16*i +: 16] = (i == bad_lane) ? bad_val : w;
        @(negedge clk);
        axis.tdata = d; axis.tkeep = keep; axis.tlast = last; axis.tvalid = 1'b1;
        clr_counts = clr;
        while (!axis.tready && waitc < 64) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 64) chk("accept_timeout", 32'(waitc), 32'd0);
        @(posedge clk);
    endtask

    task automatic stream(input logic [15:0] w0, input int n, input int pos0);
        for (int k = 0; k < n; k++)
            drive(w0 + 16'(k), -1, 16'h0, ((pos0 + k) % PKT) == PKT-1, {KW{1'b1}}, 1'b0);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        axis.tvalid = 1'b0; axis.tlast = 1'b0; clr_counts = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; axis.tvalid = 1'b0; axis.tlast = 1'b0;
        clr_counts = 1'b0; throttle = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; throttle = 1'b0; clr_counts = 1'b0;
        axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tdata = '0; axis.tkeep = '1;
        repeat (3) @(negedge clk);
        chk("rst_tready", 32'(axis.tready), 32'd0);
        chk("rst_pkt", pkt_count, 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("tready_rise", 32'(axis.tready), 32'd1);

        // clean pattern, 1000 beats
        stream(START, 1000, 0);
        idle(2);
        chk("pat_pkt", pkt_count, 32'd125);
        chk("pat_derr", 32'(data_err_count), 32'd0);
        chk("pat_ferr", 32'(frame_err_count), 32'd0);
        chk("pat_error", 32'(error), 32'd0);
        @(negedge clk) clr_counts = 1'b1;
        idle(1);
        chk("clr_pkt", pkt_count, 32'd0);

        // lane 5 of beat 20 flipped
        do_reset();
        for (int k = 0; k < 24; k++)
            drive(16'(k), (k == 20) ? 5 : -1, 16'h0014 ^ 16'h8000, (k % PKT) == PKT-1, {KW{1'b1}}, 1'b0);
        idle(2);
        chk("l5_derr", 32'(data_err_count), 32'd1);
        chk("l5_fbw", 32'(first_bad_word), 32'h0014);
        chk("l5_error", 32'(error), 32'd1);
        chk("l5_pkt", pkt_count, 32'd3);

        // lane 0 of beat 20 = 0x1234: two errors then resync
        do_reset();
        for (int k = 0; k < 32; k++)
            drive(16'(k), (k == 20) ? 0 : -1, 16'h1234, (k % PKT) == PKT-1, {KW{1'b1}}, 1'b0);
        idle(2);
        chk("l0_derr", 32'(data_err_count), 32'd2);
        chk("l0_fbw", 32'(first_bad_word), 32'h1234);
        chk("l0_pkt", pkt_count, 32'd4);

        // framing: short packet, then 9 beats; the long-packet error restarts
        // the beat count, so the trailing TLAST is also a short packet
        do_reset();
        for (int k = 0; k < 6; k++) drive(16'(k), -1, 16'h0, k == 5, {KW{1'b1}}, 1'b0);
        for (int j = 0; j < 9; j++) drive(16'(6 + j), -1, 16'h0, j == 8, {KW{1'b1}}, 1'b0);
        idle(2);
        chk("frm_ferr", 32'(frame_err_count), 32'd3);
        chk("frm_pkt", pkt_count, 32'd2);
        chk("frm_derr", 32'(data_err_count), 32'd0);
        chk("frm_fbw", 32'(first_bad_word), 32'h0);

        // partial keep, then a reset mid-packet
        do_reset();
        for (int k = 0; k < 8; k++)
            drive(16'(k), -1, 16'h0, k == 7, (k == 3) ? {{(KW-11){1'b1}}, 1'b0, 10'h3FF} : {KW{1'b1}}, 1'b0);
        idle(2);
        chk("keep_derr", 32'(data_err_count), 32'd1);
        chk("keep_fbw", 32'(first_bad_word), 32'h0003);
        stream(16'd8, 3, 0);
        do_reset();
        stream(START, 8, 0);
        idle(2);
        chk("abort_ferr", 32'(frame_err_count), 32'd0);
        chk("abort_pkt", pkt_count, 32'd1);
        chk("abort_derr", 32'(data_err_count), 32'd0);

        // clear colliding with an erroring beat, then throttled run over the wrap
        do_reset();
        stream(START, 7, 0);
        drive(16'hFFD8, -1, 16'h0, 1'b1, {KW{1'b1}}, 1'b1);
        idle(1);
        chk("coll_pkt", pkt_count, 32'd0);
        chk("coll_derr", 32'(data_err_count), 32'd0);
        chk("coll_error", 32'(error), 32'd0);
        throttle = 1'b1;
        thr_phase = 1'b1;
        stream(16'hFFD9, 64, 0);
        idle(2);
        thr_phase = 1'b0;
        throttle = 1'b0;
        chk("thr_pkt", pkt_count, 32'd8);
        chk("thr_derr", 32'(data_err_count), 32'd0);
        chk("thr_ferr", 32'(frame_err_count), 32'd0);
        chk("thr_error", 32'(error), 32'd0);
        chk("thr_low_ratio_ok", 32'(ph_low * 100 >= ph_cyc * 8 && ph_low * 100 <= ph_cyc * 45), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
